// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem request at a
// time, buffers a single fetched word for decode and handles execute redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic        misalign_o
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            buf_valid_q, buf_valid_d;
  logic [XLEN-1:0] buf_instr_q, buf_instr_d;
  logic [XLEN-1:0] buf_pc_q, buf_pc_d;

  logic redirect_en;
  logic xfer;

  // Redirects are only honoured once the fetch loop is running.
  assign redirect_en = redirect_i && (state_q != S_BOOT);
  assign xfer        = buf_valid_q && instr_ready_i;

  // Next-state and datapath update; a redirect overrides whatever the state chose.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    buf_valid_d   = buf_valid_q;
    buf_instr_d   = buf_instr_q;
    buf_pc_d      = buf_pc_q;

    case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        if (redirect_en) begin
          // A grant racing the redirect is for the old PC and must be dropped.
          state_d = imem_gnt_i ? S_DROP : S_REQ;
        end else if (imem_gnt_i) begin
          inflight_pc_d = fetch_pc_q;
          fetch_pc_d    = fetch_pc_q + XLEN'(4);
          state_d       = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_en) begin
          state_d = imem_rvalid_i ? S_REQ : S_DROP;
        end else if (imem_rvalid_i) begin
          buf_valid_d = 1'b1;
          buf_instr_d = imem_rdata_i;
          buf_pc_d    = inflight_pc_q;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_en) begin
          state_d = S_REQ;
        end else if (xfer) begin
          buf_valid_d = 1'b0;
          buf_instr_d = NOP;
          state_d     = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rvalid_i) state_d = S_REQ;
      end
      default: state_d = S_BOOT;
    endcase

    if (redirect_en) begin
      fetch_pc_d  = {redirect_pc_i[XLEN-1:2], 2'b00};
      buf_valid_d = 1'b0;
      buf_instr_d = NOP;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q       <= S_BOOT;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      buf_valid_q   <= 1'b0;
      buf_instr_q   <= NOP;
      buf_pc_q      <= RESET_PC;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      buf_valid_q   <= buf_valid_d;
      buf_instr_q   <= buf_instr_d;
      buf_pc_q      <= buf_pc_d;
    end
  end

  // Bus and decode outputs come straight from registers; misalign is a same-cycle flag.
  assign imem_req_o    = (state_q == S_REQ);
  assign imem_addr_o   = fetch_pc_q;
  assign instr_valid_o = buf_valid_q;
  assign instruction_o = buf_instr_q;
  assign pc_o          = buf_pc_q;
  assign misalign_o    = redirect_en && (redirect_pc_i[1:0] != 2'b00);

endmodule
